// File: rtl/label_allocator.sv
// Label-table write sequencer: bump-pointer base allocation per request, plus a bulk clear sweep.
// Latency: the MMU write (we) and done appear one cycle after the request is accepted.
// Backpressure: req_ready is low while busy or while clr_start is high; one grant every 2 cycles at most.
module label_allocator #(
    parameter int          MEM_TOP        = 32768,
    parameter int          LBID_MAX       = 4095,
    parameter logic [7:0]  LBTYPE_INVALID = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_lbid,
    input  logic [7:0]  req_type,
    input  logic [15:0] req_count,
    input  logic        clr_start,
    output logic        busy,
    output logic        done,
    output logic        err_overflow,
    output logic [15:0] free_ptr,
    output logic [11:0] lbidw,
    output logic [7:0]  lbTypew,
    output logic [15:0] basew,
    output logic [15:0] countw,
    output logic        we
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

    localparam logic [16:0] W_MEM_TOP  = 17'(MEM_TOP);
    localparam logic [12:0] CLR_LAST   = 13'(LBID_MAX);
    localparam logic [12:0] CLR_DONE   = 13'(LBID_MAX + 1);

    state_t      r_state,    w_state_nxt;
    logic [15:0] r_free_ptr, w_free_ptr_nxt;
    logic [11:0] r_lbidw,    w_lbidw_nxt;
    logic [7:0]  r_lbtypew,  w_lbtypew_nxt;
    logic [15:0] r_basew,    w_basew_nxt;
    logic [15:0] r_countw,   w_countw_nxt;
    logic        r_we,       w_we_nxt;
    logic        r_done,     w_done_nxt;
    logic        r_err,      w_err_nxt;
    logic [12:0] r_clr_cnt,  w_clr_cnt_nxt;
    logic [16:0] w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_free_ptr <= '0;
            r_lbidw    <= '0;
            r_lbtypew  <= '0;
            r_basew    <= '0;
            r_countw   <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_clr_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_free_ptr <= w_free_ptr_nxt;
            r_lbidw    <= w_lbidw_nxt;
            r_lbtypew  <= w_lbtypew_nxt;
            r_basew    <= w_basew_nxt;
            r_countw   <= w_countw_nxt;
            r_we       <= w_we_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
        end
    end

    // 17-bit sum so a request running past the top of memory cannot wrap.
    assign w_sum = {1'b0, r_free_ptr} + {1'b0, req_count};

    always_comb begin
        w_state_nxt    = r_state;
        w_free_ptr_nxt = r_free_ptr;
        w_lbidw_nxt    = r_lbidw;
        w_lbtypew_nxt  = r_lbtypew;
        w_basew_nxt    = r_basew;
        w_countw_nxt   = r_countw;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_we_nxt       = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt   = S_CLEAR;
                    w_we_nxt      = 1'b1;
                    w_lbidw_nxt   = '0;
                    w_lbtypew_nxt = LBTYPE_INVALID;
                    w_basew_nxt   = '0;
                    w_countw_nxt  = '0;
                    w_clr_cnt_nxt = 13'd1;
                end else if (req_valid) begin
                    if (req_count == 16'd0 || w_sum > W_MEM_TOP) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_WRITE;
                        w_we_nxt       = 1'b1;
                        w_done_nxt     = 1'b1;
                        w_lbidw_nxt    = req_lbid;
                        w_lbtypew_nxt  = req_type;
                        w_basew_nxt    = r_free_ptr;
                        w_countw_nxt   = req_count;
                        w_free_ptr_nxt = w_sum[15:0];
                    end
                end
            end
            S_WRITE: w_state_nxt = S_IDLE;
            S_CLEAR: begin
                // Counter runs one past LBID_MAX to hold the done cycle inside CLEAR.
                if (r_clr_cnt <= CLR_LAST) begin
                    w_we_nxt      = 1'b1;
                    w_lbidw_nxt   = r_clr_cnt[11:0];
                    w_clr_cnt_nxt = r_clr_cnt + 13'd1;
                end else if (r_clr_cnt == CLR_DONE) begin
                    w_done_nxt     = 1'b1;
                    w_free_ptr_nxt = '0;
                    w_clr_cnt_nxt  = r_clr_cnt + 13'd1;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req_ready    = (r_state == S_IDLE) && !clr_start;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign err_overflow = r_err;
    assign free_ptr     = r_free_ptr;
    assign lbidw        = r_lbidw;
    assign lbTypew      = r_lbtypew;
    assign basew        = r_basew;
    assign countw       = r_countw;
    assign we           = r_we;

endmodule

// File: tb/tb_label_allocator.sv
// Randomized scoreboard bench for label_allocator with a bump-pointer reference model.
module tb_label_allocator;

    localparam int MEM_TOP  = 64;
    localparam int LBID_MAX = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_lbid = '0;
    logic [7:0]  req_type = '0;
    logic [15:0] req_count = '0;
    logic        clr_start = 1'b0;
    logic        busy, done, err_overflow, we;
    logic [15:0] free_ptr, basew, countw;
    logic [11:0] lbidw;
    logic [7:0]  lbTypew;

    label_allocator #(.MEM_TOP(MEM_TOP), .LBID_MAX(LBID_MAX), .LBTYPE_INVALID(8'h00)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_lbid(req_lbid), .req_type(req_type), .req_count(req_count),
        .clr_start(clr_start), .busy(busy), .done(done), .err_overflow(err_overflow),
        .free_ptr(free_ptr), .lbidw(lbidw), .lbTypew(lbTypew), .basew(basew),
        .countw(countw), .we(we)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          we, done, err;
        logic [11:0] lbid;
        logic [7:0]  typ;
        logic [15:0] base, cnt, fp;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  started = 0;
    int  m_fp = 0;     // model free pointer
    int  m_busy = 0;   // model: cycles remaining in which no request is taken

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observable event is matched against the head of the queue.
    always @(negedge clk) begin
        if (we === 1'b1 || done === 1'b1 || err_overflow === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual we=%b done=%b err=%b lbid=%0d required none", we, done, err_overflow, lbidw);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_flags", {29'd0, we, done, err_overflow}, {29'd0, e.we, e.done, e.err});
                chk("ev_free_ptr", {16'd0, free_ptr}, {16'd0, e.fp});
                if (e.we)
                    chk("ev_write", {lbidw, lbTypew, basew, countw}, {e.lbid, e.typ, e.base, e.cnt});
            end
        end
    end

    function automatic ev_t mk(int c, bit w, bit d, bit r, int l, int t, int b, int n, int f);
        ev_t e;
        e.cyc = c; e.we = w; e.done = d; e.err = r;
        e.lbid = 12'(l); e.typ = 8'(t); e.base = 16'(b); e.cnt = 16'(n); e.fp = 16'(f);
        return e;
    endfunction

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input bit v, input int l, input int t, input int c, input bit clr, input bit rst);
        req_valid = v; req_lbid = 12'(l); req_type = 8'(t); req_count = 16'(c);
        clr_start = clr; reset = rst;
        #1;
        if (started && !rst) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, (m_busy == 0) && !clr});
            chk("busy", {31'd0, busy}, {31'd0, m_busy > 0});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_fp = 0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (clr) begin
            for (int k = 0; k <= LBID_MAX; k++)
                q.push_back(mk(cyc + k, 1, 0, 0, k, 0, 0, 0, m_fp));
            q.push_back(mk(cyc + LBID_MAX + 1, 0, 1, 0, 0, 0, 0, 0, 0));
            m_fp = 0;
            m_busy = LBID_MAX + 2;
        end else if (v) begin
            if (c == 0 || m_fp + c > MEM_TOP) begin
                q.push_back(mk(cyc, 0, 0, 1, 0, 0, 0, 0, m_fp));
            end else begin
                q.push_back(mk(cyc, 1, 1, 0, l, t, m_fp, c, m_fp + c));
                m_fp += c;
                m_busy = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        started = 1;
        chk("rst_free_ptr", {16'd0, free_ptr}, 32'd0);
        chk("rst_flags", {28'd0, we, done, err_overflow, busy}, 32'd0);
        chk("rst_outs", {lbidw, lbTypew, basew[11:0]}, 32'd0);
        chk("rst_countw", {16'd0, countw}, 32'd0);

        // Two grants filling memory, then overflow by one word.
        step(1, 3, 8'h02, 32, 0, 0);
        chk("grant1_ptr", {16'd0, free_ptr}, 32'd32);
        step(0, 0, 0, 0, 0, 0);
        step(1, 5, 8'h03, 32, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 9, 8'h03, 1, 0, 0);
        step(1, 9, 8'h03, 0, 0, 0);
        idle(1);

        // Clear wins over a simultaneous request.
        step(1, 1, 8'h04, 4, 1, 0);
        idle(LBID_MAX + 3);
        chk("clear_ptr", {16'd0, free_ptr}, 32'd0);

        // Exact fit to the top of memory, then one word too many.
        step(1, 1, 8'h01, 32, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 2, 8'h01, 28, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 4, 8'h01, 4, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("exact_fit_ptr", {16'd0, free_ptr}, 32'd64);
        step(1, 4, 8'h01, 1, 0, 0);
        idle(1);

        // Reset asserted in the third clear cycle.
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1);
        chk("midclr_rst", {29'd0, we, busy, done}, 32'd0);
        chk("midclr_ptr", {16'd0, free_ptr}, 32'd0);
        idle(1);

        // Held request: fields change every cycle, only accepted values matter.
        for (int i = 0; i < 10; i++)
            step(1, $urandom_range(0, 4095), $urandom_range(0, 255), 8, 0, 0);
        idle(1);

        for (int i = 0; i < 500; i++) begin
            int c;
            c = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4095), $urandom_range(0, 255), c,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
        end
        idle(LBID_MAX + 4);
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
